// File: rtl/branch_ctrl_seq.sv
// Fetch / conditional-branch control sequencer: one T-state per clock, drives datapath control ports.
// Optional MEM_WAIT_EN: T1 stalls on mem_rdy; undefined, T1 is a single cycle.
module branch_ctrl_seq #(
   parameter logic [4:0] OPC_BR   = 5'b10010,
   parameter logic [5:0] ALU_ADD  = 6'd0,
   parameter logic [5:0] ALU_IDLE = 6'd13,
   parameter int         CNT_W    = 16
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             run,
   input  logic [31:0]      ir,
   input  logic             con_ff,
   input  logic             mem_rdy,
   output logic [31:0]      enc_input,
   output logic [31:0]      reg_enable,
   output logic             incPC,
   output logic             read,
   output logic             write,
   output logic [3:0]       Gra,
   output logic [3:0]       Grb,
   output logic [3:0]       Grc,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic             conIn,
   output logic [5:0]       ALU_Sel,
   output logic             busy,
   output logic             br_taken,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ill_q, ill_d;

   // Bus-source / register-enable bit positions within the datapath encoders.
   localparam int B_ZLO = 19;
   localparam int B_PC  = 20;
   localparam int B_IR  = 21;
   localparam int B_MDR = 22;
   localparam int B_MAR = 23;
   localparam int B_Y   = 24;
   localparam int B_C   = 25;

`ifdef MEM_WAIT_EN
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[22:0];
`else
   logic unused_in_bits;
   assign unused_in_bits = ^{ir[22:0], mem_rdy};
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ill_d   = 1'b0;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   state_d = S_T1;
`ifdef MEM_WAIT_EN
         S_T1:   if (mem_rdy) state_d = S_T2;
`else
         S_T1:   state_d = S_T2;
`endif
         S_T2: begin
            if (ir[31:27] == OPC_BR) begin
               state_d = S_T3;
            end else begin
               state_d = S_IDLE;
               ill_d   = 1'b1;
            end
         end
         S_T3:   state_d = S_T4;
         S_T4:   state_d = S_T5;
         S_T5:   state_d = S_T6;
         S_T6: begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = run ? S_T0 : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      enc_input  = '0;
      reg_enable = '0;
      incPC      = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      Gra        = '0;
      Grb        = '0;
      Grc        = '0;
      Rin        = 1'b0;
      Rout       = 1'b0;
      BAout      = 1'b0;
      conIn      = 1'b0;
      ALU_Sel    = ALU_IDLE;
      br_taken   = 1'b0;
      unique case (state_q)
         S_T0: begin
            enc_input[B_PC]   = 1'b1;
            reg_enable[B_MAR] = 1'b1;
            incPC             = 1'b1;
         end
         S_T1: begin
            read              = 1'b1;
            reg_enable[B_MDR] = 1'b1;
         end
         S_T2: begin
            enc_input[B_MDR]  = 1'b1;
            reg_enable[B_IR]  = 1'b1;
         end
         S_T3: begin
            Gra   = ir[26:23];
            Rout  = 1'b1;
            conIn = 1'b1;
         end
         S_T4: begin
            enc_input[B_PC]   = 1'b1;
            reg_enable[B_Y]   = 1'b1;
         end
         S_T5: begin
            enc_input[B_C]    = 1'b1;
            reg_enable[B_ZLO] = 1'b1;
            ALU_Sel           = ALU_ADD;
         end
         // Only T6 looks at con_ff: the branch target is loaded into PC only when taken.
         S_T6: begin
            if (con_ff) begin
               enc_input[B_ZLO] = 1'b1;
               reg_enable[B_PC] = 1'b1;
               br_taken         = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign illegal   = ill_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Randomized self-checking bench for branch_ctrl_seq; a second instance with a 3-bit counter exposes wrap-around.
// Expected outputs come from a per-T-state table of the control word and a simple instruction-count model.
module tb_branch_ctrl_seq;

   logic        clock, clr_n, run, con_ff, mem_rdy;
   logic [31:0] ir;
   logic [31:0] enc_input, reg_enable;
   logic        incPC, read, write, Rin, Rout, BAout, conIn, busy, br_taken, illegal;
   logic [3:0]  Gra, Grb, Grc;
   logic [5:0]  ALU_Sel;
   logic [15:0] instr_cnt;

   logic [31:0] w_enc, w_reg;
   logic        w_inc, w_rd, w_wr, w_rin, w_rout, w_ba, w_con, w_busy, w_br, w_ill;
   logic [3:0]  w_gra, w_grb, w_grc;
   logic [5:0]  w_alu;
   logic [2:0]  w_cnt;

   typedef struct packed {
      logic [31:0] enc;
      logic [31:0] regen;
      logic        incpc, read, write;
      logic [3:0]  gra, grb, grc;
      logic        rin, rout, baout, conin;
      logic [5:0]  alu;
      logic        busy, br_taken, illegal;
   } outs_t;

   outs_t got;
   assign got = {enc_input, reg_enable, incPC, read, write, Gra, Grb, Grc,
                 Rin, Rout, BAout, conIn, ALU_Sel, busy, br_taken, illegal};

   branch_ctrl_seq dut (
      .clock(clock), .clr_n(clr_n), .run(run), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy),
      .enc_input(enc_input), .reg_enable(reg_enable), .incPC(incPC), .read(read), .write(write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .conIn(conIn),
      .ALU_Sel(ALU_Sel), .busy(busy), .br_taken(br_taken), .illegal(illegal), .instr_cnt(instr_cnt)
   );

   branch_ctrl_seq #(.CNT_W(3)) dut_w (
      .clock(clock), .clr_n(clr_n), .run(run), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy),
      .enc_input(w_enc), .reg_enable(w_reg), .incPC(w_inc), .read(w_rd), .write(w_wr),
      .Gra(w_gra), .Grb(w_grb), .Grc(w_grc), .Rin(w_rin), .Rout(w_rout), .BAout(w_ba), .conIn(w_con),
      .ALU_Sel(w_alu), .busy(w_busy), .br_taken(w_br), .illegal(w_ill), .instr_cnt(w_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int m_cnt = 0;      // completed branches since last reset
   int rdy_after = 0;  // cycle index from which mem_rdy is driven high (stall builds)

   outs_t       obs[16];
   logic [15:0] obs_cnt[16];
   logic [2:0]  obs_w[16];

   // Control word each T-state must present, straight from the state table.
   function automatic outs_t exp_outs(int step, logic [31:0] iv, logic con, logic ill);
      outs_t o;
      o         = '0;
      o.alu     = 6'd13;
      o.busy    = (step >= 0);
      o.illegal = ill;
      case (step)
         0: begin o.enc[20] = 1'b1; o.regen[23] = 1'b1; o.incpc = 1'b1; end
         1: begin o.read = 1'b1; o.regen[22] = 1'b1; end
         2: begin o.enc[22] = 1'b1; o.regen[21] = 1'b1; end
         3: begin o.gra = iv[26:23]; o.rout = 1'b1; o.conin = 1'b1; end
         4: begin o.enc[20] = 1'b1; o.regen[24] = 1'b1; end
         5: begin o.enc[25] = 1'b1; o.regen[19] = 1'b1; o.alu = 6'd0; end
         6: if (con) begin o.enc[19] = 1'b1; o.regen[20] = 1'b1; o.br_taken = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   // Cycle k after launch: a branch spends 7 cycles in T0..T6, an illegal opcode 3 then one flagged idle cycle.
   function automatic outs_t exp_at(int k, logic legal, logic [31:0] iv, logic con);
      int step;
      step = legal ? ((k < 7) ? k : -1) : ((k < 3) ? k : -1);
      return exp_outs(step, iv, con, !legal && k == 3);
   endfunction

   // Launch one instruction on the next edge (run already high) and record n negedge samples.
   task automatic drive_instr(input logic [31:0] iv, input logic con, input int n, input int drop_at);
      ir     = iv;
      con_ff = con;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         obs[k]     = got;
         obs_cnt[k] = instr_cnt;
         obs_w[k]   = w_cnt;
`ifdef MEM_WAIT_EN
         mem_rdy = (k >= rdy_after);
`else
         mem_rdy = 1'($urandom);
`endif
         if (k == drop_at) run = 1'b0;
      end
   endtask

   function automatic logic [31:0] rand_ir(logic legal);
      logic [31:0] v;
      logic [4:0]  op;
      v  = $urandom;
      op = 5'($urandom);
      if (op == 5'b10010) op = 5'b00000;
      v[31:27] = legal ? 5'b10010 : op;
      return v;
   endfunction

   task automatic test_reset();
      outs_t e;
      clr_n = 1'b0; run = 1'b1; ir = 32'h9100_0023; con_ff = 1'b1;
      e = exp_outs(-1, ir, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         tests++;
         if (got !== e || instr_cnt !== 16'd0 || w_cnt !== 3'd0) begin
            fails++;
            $display("FAIL reset i=%0d out=%h want=%h cnt=%h", i, got, e, instr_cnt);
         end
      end
      run = 1'b0; clr_n = 1'b1; m_cnt = 0;
      @(negedge clock);
      tests++;
      if (got !== e || instr_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset_release out=%h want=%h", got, e);
      end
   endtask

   task automatic test_branch(input string name, input logic con);
      logic [31:0] iv;
      outs_t e;
      int ec;
      iv = 32'h9100_0023;
      run = 1'b1;
      drive_instr(iv, con, 8, 6);
      for (int k = 0; k < 8; k++) begin
         e  = exp_at(k, 1'b1, iv, con);
         ec = (k == 7) ? m_cnt + 1 : m_cnt;
         tests++;
         if (obs[k] !== e || obs_cnt[k] !== 16'(ec) || obs_w[k] !== 3'(ec)) begin
            fails++;
            $display("FAIL %s k=%0d out=%h want=%h cnt=%h want=%h", name, k, obs[k], e, obs_cnt[k], 16'(ec));
         end
      end
      m_cnt++;
   endtask

   task automatic test_illegal();
      logic [31:0] iv;
      outs_t e;
      iv = 32'h0800_0000;
      run = 1'b1;
      drive_instr(iv, 1'b1, 5, 2);
      for (int k = 0; k < 5; k++) begin
         e = exp_at(k, 1'b0, iv, 1'b1);
         tests++;
         if (obs[k] !== e || obs_cnt[k] !== 16'(m_cnt)) begin
            fails++;
            $display("FAIL illegal k=%0d out=%h want=%h cnt=%h want=%h", k, obs[k], e, obs_cnt[k], 16'(m_cnt));
         end
      end
   endtask

   // run drops during T3: the branch still completes before returning to idle.
   task automatic test_run_drop();
      logic [31:0] iv;
      outs_t e;
      int ec;
      iv = rand_ir(1'b1);
      run = 1'b1;
      drive_instr(iv, 1'b0, 9, 3);
      for (int k = 0; k < 9; k++) begin
         e  = exp_at(k, 1'b1, iv, 1'b0);
         ec = (k >= 7) ? m_cnt + 1 : m_cnt;
         tests++;
         if (obs[k] !== e || obs_cnt[k] !== 16'(ec)) begin
            fails++;
            $display("FAIL run_drop k=%0d out=%h want=%h cnt=%h want=%h", k, obs[k], e, obs_cnt[k], 16'(ec));
         end
      end
      m_cnt++;
   endtask

   task automatic test_back_to_back(input string name, input int count);
      logic [31:0] iv;
      logic con;
      outs_t e;
      int ec, n, busy_cycles;
      busy_cycles = 0;
      run = 1'b1;
      for (int i = 0; i < count; i++) begin
         iv  = rand_ir(1'b1);
         con = 1'($urandom);
         n   = (i == count - 1) ? 8 : 7;
         drive_instr(iv, con, n, (i == count - 1) ? 6 : -1);
         for (int k = 0; k < n; k++) begin
            e  = exp_at(k, 1'b1, iv, con);
            ec = (k == 7) ? m_cnt + 1 : m_cnt;
            busy_cycles += int'(obs[k].busy);
            tests++;
            if (obs[k] !== e || obs_cnt[k] !== 16'(ec) || obs_w[k] !== 3'(ec)) begin
               fails++;
               $display("FAIL %s i=%0d k=%0d out=%h want=%h cnt=%h/%h cntw=%h/%h", name, i, k,
                        obs[k], e, obs_cnt[k], 16'(ec), obs_w[k], 3'(ec));
            end
         end
         m_cnt++;
      end
      tests++;
      if (busy_cycles != 7 * count) begin
         fails++;
         $display("FAIL %s_busy got=%0d want=%0d", name, busy_cycles, 7 * count);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] iv;
      outs_t e;
      iv = rand_ir(1'b1);
      run = 1'b1;
      drive_instr(iv, 1'b1, 5, -1);
      tests++;
      e = exp_at(4, 1'b1, iv, 1'b1);
      if (obs[4] !== e) begin
         fails++;
         $display("FAIL reset_mid_t4 out=%h want=%h", obs[4], e);
      end
      #2 clr_n = 1'b0;
      #1;
      m_cnt = 0;
      e = exp_outs(-1, iv, 1'b0, 1'b0);
      tests++;
      if (got !== e || instr_cnt !== 16'd0 || w_cnt !== 3'd0) begin
         fails++;
         $display("FAIL reset_mid_async out=%h want=%h cnt=%h", got, e, instr_cnt);
      end
      @(negedge clock);
      tests++;
      if (got !== e) begin
         fails++;
         $display("FAIL reset_mid_hold out=%h want=%h", got, e);
      end
      clr_n = 1'b1;
      test_branch("reset_restart", 1'b1);
   endtask

   task automatic test_random();
      logic [31:0] iv;
      logic legal, con, last;
      outs_t e;
      int ec, len, n;
      run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         legal = ($urandom_range(3, 0) != 0);
         iv    = rand_ir(legal);
         con   = 1'($urandom);
         last  = (i == 9);
         len   = legal ? 7 : 4;
         n     = last ? len + 1 : len;
         drive_instr(iv, con, n, last ? len - 1 : -1);
         for (int k = 0; k < n; k++) begin
            e  = exp_at(k, legal, iv, con);
            ec = (legal && k >= 7) ? m_cnt + 1 : m_cnt;
            tests++;
            if (obs[k] !== e || obs_cnt[k] !== 16'(ec) || obs_w[k] !== 3'(ec)) begin
               fails++;
               $display("FAIL random i=%0d k=%0d ir=%h out=%h want=%h cnt=%h want=%h", i, k, iv,
                        obs[k], e, obs_cnt[k], 16'(ec));
            end
         end
         if (legal) m_cnt++;
      end
   endtask

`ifdef MEM_WAIT_EN
   // mem_rdy low for three T1 cycles: T1 spans four cycles, branch takes ten.
   task automatic test_mem_wait();
      logic [31:0] iv;
      outs_t e;
      int step, ec, busy_cycles;
      iv = rand_ir(1'b1);
      busy_cycles = 0;
      rdy_after = 4;
      run = 1'b1;
      drive_instr(iv, 1'b1, 11, 9);
      for (int k = 0; k < 11; k++) begin
         step = (k == 0) ? 0 : (k <= 4) ? 1 : (k <= 9) ? k - 3 : -1;
         e  = exp_outs(step, iv, 1'b1, 1'b0);
         ec = (k == 10) ? m_cnt + 1 : m_cnt;
         busy_cycles += int'(obs[k].busy);
         tests++;
         if (obs[k] !== e || obs_cnt[k] !== 16'(ec)) begin
            fails++;
            $display("FAIL mem_wait k=%0d out=%h want=%h cnt=%h want=%h", k, obs[k], e, obs_cnt[k], 16'(ec));
         end
      end
      tests++;
      if (busy_cycles != 10) begin
         fails++;
         $display("FAIL mem_wait_latency got=%0d want=10", busy_cycles);
      end
      m_cnt++;
      rdy_after = 0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef MEM_WAIT_EN
      mem_rdy = 1'b1;
`else
      mem_rdy = 1'b0;
`endif
      test_reset();
      test_branch("brzr_taken", 1'b1);
      test_branch("brzr_not_taken", 1'b0);
      test_illegal();
      test_run_drop();
      test_back_to_back("back_to_back", 3);
      test_reset_mid();
      test_back_to_back("wrap", 9);
      test_random();
`ifdef MEM_WAIT_EN
      test_mem_wait();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
